// File: rtl/bg_pkg.sv
// Shared constants and types for the background label ROM arbiter.
// Define BG_OOB_CLAMP_EN to suppress reads for off-screen coordinates and return label 0.
package bg_pkg;

    localparam int BG_HORIZONTAL = 320;
    localparam int BG_VERTICAL   = 220;
    localparam int BG_PIXEL_BITS = 3;
    localparam int BG_ADDR_W     = 17;

`ifdef BG_OOB_CLAMP_EN
    localparam bit BG_OOB_CLAMP = 1'b1;
`else
    localparam bit BG_OOB_CLAMP = 1'b0;
`endif

    typedef enum logic [1:0] {
        G_IDLE,
        G_PEND,
        G_WAIT
    } game_state_t;

endpackage

// File: rtl/bg_addr_gen.sv
// Maps a 640x440 screen coordinate onto the half-resolution stored background.
// Also flags coordinates that fall outside the screen.
module bg_addr_gen
    import bg_pkg::*;
#(
    parameter int HORIZONTAL = BG_HORIZONTAL,
    parameter int VERTICAL   = BG_VERTICAL
) (
    input  logic [9:0]           x,
    input  logic [8:0]           y,
    output logic [BG_ADDR_W-1:0] addr,
    output logic                 oob
);

    assign addr = BG_ADDR_W'(y[8:1]) * BG_ADDR_W'(HORIZONTAL) + BG_ADDR_W'(x[9:1]);

    // The flag is forced low unless clamping is built in, so off-screen reads go out unchecked.
    assign oob = BG_OOB_CLAMP &
                 ((32'(x) >= 32'(2 * HORIZONTAL)) | (32'(y) >= 32'(2 * VERTICAL)));

endmodule

// File: rtl/bg_rom_arbiter.sv
// Shares one label memory port between the display fetch (absolute priority) and game lookups.
// Optional macro BG_OOB_CLAMP_EN: off-screen requests skip the memory and return label 0.
module bg_rom_arbiter
    import bg_pkg::*;
#(
    parameter int HORIZONTAL = BG_HORIZONTAL,
    parameter int VERTICAL   = BG_VERTICAL,
    parameter int PIXEL_BITS = BG_PIXEL_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_disp_req,
    input  logic [9:0]            i_disp_x,
    input  logic [8:0]            i_disp_y,
    output logic                  o_disp_valid,
    output logic [PIXEL_BITS-1:0] o_disp_label,
    input  logic                  i_game_valid,
    output logic                  o_game_ready,
    input  logic [9:0]            i_game_x,
    input  logic [8:0]            i_game_y,
    output logic                  o_game_rvalid,
    output logic [PIXEL_BITS-1:0] o_game_label,
    output logic                  o_mem_en,
    output logic [BG_ADDR_W-1:0]  o_mem_addr,
    input  logic [PIXEL_BITS-1:0] i_mem_data,
    output logic [15:0]           o_game_wait
);

    game_state_t state_q, state_d;

    logic [9:0]            pend_x_q;
    logic [8:0]            pend_y_q;
    logic [15:0]           wait_q;
    logic [BG_ADDR_W-1:0]  disp_addr, game_addr, mem_addr_q;
    logic                  disp_oob, game_oob;
    logic                  game_hs, game_issue;
    logic                  mem_en_q;
    logic                  s1_disp_q, s1_game_q, s1_oob_q;
    logic                  s2_disp_q, s2_game_q, s2_oob_q;
    logic [PIXEL_BITS-1:0] mem_label, disp_hold_q, game_hold_q;

    bg_addr_gen #(.HORIZONTAL(HORIZONTAL), .VERTICAL(VERTICAL)) u_disp_addr (
        .x    (i_disp_x),
        .y    (i_disp_y),
        .addr (disp_addr),
        .oob  (disp_oob)
    );

    bg_addr_gen #(.HORIZONTAL(HORIZONTAL), .VERTICAL(VERTICAL)) u_game_addr (
        .x    (pend_x_q),
        .y    (pend_y_q),
        .addr (game_addr),
        .oob  (game_oob)
    );

    assign game_hs    = i_game_valid && (state_q == G_IDLE);
    assign game_issue = (state_q == G_PEND) && !i_disp_req;

    // G_WAIT lasts exactly the issue cycle, so the machine is idle again as the response lands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            G_IDLE:  if (game_hs) state_d = G_PEND;
            G_PEND:  if (game_issue) state_d = G_WAIT;
            G_WAIT:  state_d = G_IDLE;
            default: state_d = G_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= G_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_x_q <= '0;
            pend_y_q <= '0;
            wait_q   <= '0;
        end else if (game_hs) begin
            pend_x_q <= i_game_x;
            pend_y_q <= i_game_y;
            wait_q   <= '0;
        end else if ((state_q == G_PEND) && (wait_q != 16'hFFFF)) begin
            wait_q <= wait_q + 16'd1;
        end
    end

    // Two-stage read pipeline: stage 1 drives the memory, stage 2 sees its data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            s1_disp_q  <= 1'b0;
            s1_game_q  <= 1'b0;
            s1_oob_q   <= 1'b0;
            s2_disp_q  <= 1'b0;
            s2_game_q  <= 1'b0;
            s2_oob_q   <= 1'b0;
        end else begin
            s1_disp_q <= i_disp_req;
            s1_game_q <= game_issue;
            if (i_disp_req) begin
                mem_en_q   <= !disp_oob;
                mem_addr_q <= disp_addr;
                s1_oob_q   <= disp_oob;
            end else if (game_issue) begin
                mem_en_q   <= !game_oob;
                mem_addr_q <= game_addr;
                s1_oob_q   <= game_oob;
            end else begin
                mem_en_q   <= 1'b0;
                s1_oob_q   <= 1'b0;
            end
            s2_disp_q <= s1_disp_q;
            s2_game_q <= s1_game_q;
            s2_oob_q  <= s1_oob_q;
        end
    end

    assign mem_label = s2_oob_q ? '0 : i_mem_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            disp_hold_q <= '0;
            game_hold_q <= '0;
        end else begin
            if (s2_disp_q) disp_hold_q <= mem_label;
            if (s2_game_q) game_hold_q <= mem_label;
        end
    end

    assign o_mem_en      = mem_en_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_disp_valid  = s2_disp_q;
    assign o_disp_label  = s2_disp_q ? mem_label : disp_hold_q;
    assign o_game_rvalid = s2_game_q;
    assign o_game_label  = s2_game_q ? mem_label : game_hold_q;
    assign o_game_ready  = (state_q == G_IDLE);
    assign o_game_wait   = wait_q;

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Self-checking bench for bg_rom_arbiter: a cycle scoreboard of expected reads and responses.
// Honours BG_OOB_CLAMP_EN when the design is built with it.
module tb_bg_rom_arbiter;

    typedef struct {
        int         cyc;
        logic [2:0] label;
        bit         chk;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [16:0] addr;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_req = 1'b0;
    logic [9:0]  disp_x = '0;
    logic [8:0]  disp_y = '0;
    logic        disp_valid;
    logic [2:0]  disp_label;
    logic        game_valid = 1'b0;
    logic        game_ready;
    logic [9:0]  game_x = '0;
    logic [8:0]  game_y = '0;
    logic        game_rvalid;
    logic [2:0]  game_label;
    logic        mem_en;
    logic [16:0] mem_addr;
    logic [2:0]  mem_data = '0;
    logic [15:0] game_wait;

    resp_t disp_q[$];
    resp_t game_q[$];
    rd_t   mem_q[$];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cur = 0;
    bit          checks_on = 1'b0;
    int          gst = 0;
    int          wait_m = 0;
    logic [9:0]  pend_x = '0;
    logic [8:0]  pend_y = '0;
    logic [2:0]  last_disp = '0;
    logic [2:0]  last_game = '0;
    bit          disp_known = 1'b1;
    bit          game_known = 1'b1;
    logic        prev_en = 1'b0;
    logic [16:0] prev_addr = '0;

    bg_rom_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_disp_req    (disp_req),
        .i_disp_x      (disp_x),
        .i_disp_y      (disp_y),
        .o_disp_valid  (disp_valid),
        .o_disp_label  (disp_label),
        .i_game_valid  (game_valid),
        .o_game_ready  (game_ready),
        .i_game_x      (game_x),
        .i_game_y      (game_y),
        .o_game_rvalid (game_rvalid),
        .o_game_label  (game_label),
        .o_mem_en      (mem_en),
        .o_mem_addr    (mem_addr),
        .i_mem_data    (mem_data),
        .o_game_wait   (game_wait)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_addr(logic [9:0] x, logic [8:0] y);
        int a;
        a = (int'(y) / 2) * 320 + int'(x) / 2;
        return 17'(a);
    endfunction

    function automatic bit is_oob(logic [9:0] x, logic [8:0] y);
        return (int'(x) >= 640) || (int'(y) >= 440);
    endfunction

    function automatic logic [2:0] mem_fn(logic [16:0] a);
        return 3'(a ^ (a >> 3) ^ (a >> 7));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cur);
        end
    endtask

    // Expected memory read one cycle after sampling, response two cycles after.
    task automatic issue_read(input logic [9:0] x, input logic [8:0] y, input bit is_game);
        resp_t r;
        bit    clamp;
`ifdef BG_OOB_CLAMP_EN
        clamp = is_oob(x, y);
`else
        clamp = 1'b0;
`endif
        if (!clamp) mem_q.push_back('{cur + 1, ref_addr(x, y)});
        r.cyc   = cur + 2;
        r.label = clamp ? 3'd0 : mem_fn(ref_addr(x, y));
        r.chk   = clamp || !is_oob(x, y);
        if (is_game) game_q.push_back(r);
        else         disp_q.push_back(r);
    endtask

    task automatic checkCycle();
        bit    e;
        resp_t r;
        if (!checks_on) return;
        e = (mem_q.size() > 0) && (mem_q[0].cyc == cur);
        checkOutput("mem_en", 32'(mem_en), 32'(e));
        if (e) begin
            checkOutput("mem_addr", 32'(mem_addr), 32'(mem_q[0].addr));
            void'(mem_q.pop_front());
        end
        e = (disp_q.size() > 0) && (disp_q[0].cyc == cur);
        checkOutput("disp_valid", 32'(disp_valid), 32'(e));
        if (e) begin
            r = disp_q.pop_front();
            disp_known = r.chk;
            if (r.chk) begin
                checkOutput("disp_label", 32'(disp_label), 32'(r.label));
                last_disp = r.label;
            end
        end else if (disp_known) begin
            checkOutput("disp_hold", 32'(disp_label), 32'(last_disp));
        end
        e = (game_q.size() > 0) && (game_q[0].cyc == cur);
        checkOutput("game_rvalid", 32'(game_rvalid), 32'(e));
        if (e) begin
            r = game_q.pop_front();
            game_known = r.chk;
            if (r.chk) begin
                checkOutput("game_label", 32'(game_label), 32'(r.label));
                last_game = r.label;
            end
        end else if (game_known) begin
            checkOutput("game_hold", 32'(game_label), 32'(last_game));
        end
        checkOutput("game_ready", 32'(game_ready), 32'(gst == 0));
        checkOutput("game_wait", 32'(game_wait), 32'(wait_m));
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the expectation model.
    task automatic applyStimulus(input bit r, input bit dreq, input logic [9:0] dx, input logic [8:0] dy,
                                 input bit gv, input logic [9:0] gx, input logic [8:0] gy);
        @(posedge clk);
        #1;
        cur++;
        if (prev_en) mem_data = mem_fn(prev_addr);
        rst        = r;
        disp_req   = dreq;
        disp_x     = dx;
        disp_y     = dy;
        game_valid = gv;
        game_x     = gx;
        game_y     = gy;
        @(negedge clk);
        checkCycle();
        prev_en   = mem_en;
        prev_addr = mem_addr;
        if (r) begin
            disp_q.delete();
            game_q.delete();
            mem_q.delete();
            gst        = 0;
            wait_m     = 0;
            last_disp  = '0;
            last_game  = '0;
            disp_known = 1'b1;
            game_known = 1'b1;
        end else begin
            if (dreq) issue_read(dx, dy, 1'b0);
            case (gst)
                0: if (gv) begin
                    gst    = 1;
                    pend_x = gx;
                    pend_y = gy;
                    wait_m = 0;
                end
                1: begin
                    if (wait_m < 65535) wait_m++;
                    if (!dreq) begin
                        issue_read(pend_x, pend_y, 1'b1);
                        gst = 2;
                    end
                end
                default: gst = 0;
            endcase
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        checks_on = 1'b1;
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(3);

        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 10'd100, 9'd50);
        idle(5);

        for (int x = 0; x < 640; x++) applyStimulus(1'b0, 1'b1, 10'(x), 9'd10, 1'b0, '0, '0);
        idle(4);

        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 1'b1, 10'(i * 30), 9'(i * 20), i == 0, 10'd33, 9'd77);
        idle(5);

        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 10'($urandom_range(639)), 9'($urandom_range(439)));
        idle(4);

        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 10'd700, 9'd0);
        idle(4);
        applyStimulus(1'b0, 1'b1, 10'd650, 9'd450, 1'b0, '0, '0);
        idle(4);

        applyStimulus(1'b0, 1'b1, 10'd12, 9'd34, 1'b1, 10'd200, 9'd100);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b1, 10'd5, 9'd5, 1'b0, '0, '0);
        idle(4);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 10'd401, 9'd301);
        idle(4);

        for (int i = 0; i < 300; i++)
            applyStimulus(1'b0, 1'($urandom_range(1)), 10'($urandom_range(639)), 9'($urandom_range(439)),
                          $urandom_range(3) == 0, 10'($urandom_range(639)), 9'($urandom_range(439)));
        idle(6);

        checkOutput("sb_drained", 32'(disp_q.size() + game_q.size() + mem_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bg_rom_arbiter.md
BG_ROM_ARBITER -- requirements
Module: bg_rom_arbiter

Interface
REQ-001 SHALL have parameter HORIZONTAL, default 320, stored background width in pixels.
REQ-002 SHALL have parameter VERTICAL, default 220, stored background height in pixels.
REQ-003 SHALL have parameter PIXEL_BITS, default 3, label width per pixel.
REQ-004 SHALL have port i_clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports i_disp_req input 1, i_disp_x input 10, i_disp_y input 9: display fetch request, 640x440 screen coordinates.
REQ-007 SHALL have ports o_disp_valid output 1, o_disp_label output PIXEL_BITS: display response.
REQ-008 SHALL have ports i_game_valid input 1, o_game_ready output 1, i_game_x input 10, i_game_y input 9: game-logic lookup request (valid/ready).
REQ-009 SHALL have ports o_game_rvalid output 1, o_game_label output PIXEL_BITS: game lookup response.
REQ-010 SHALL have ports o_mem_en output 1, o_mem_addr output 17, i_mem_data input PIXEL_BITS: label memory, read data one cycle after o_mem_en.
REQ-011 SHALL have port o_game_wait output 16: cycles the current game request has been pending.

Function
REQ-012 SHALL issue at most one memory read per cycle; o_mem_en and o_mem_addr registered.
REQ-013 SHALL compute address as y[8:1]*HORIZONTAL + x[9:1], 17 bits.
REQ-014 SHALL give display absolute priority: i_disp_req sampled in cycle N -> read issued N+1 -> o_disp_valid high with o_disp_label = i_mem_data in N+2; fixed latency 2, fully pipelined.
REQ-015 SHALL run game state machine G_IDLE -> G_PEND (on handshake) -> G_WAIT (on issue) -> G_IDLE (on response).
REQ-016 SHALL drive o_game_ready high only in G_IDLE; handshake latches x/y into a pending register.
REQ-017 SHALL issue the pending game read in the first cycle i_disp_req is low while in G_PEND; handshake and display request in the same cycle: request latched, display issued.
REQ-018 SHALL pulse o_game_rvalid one cycle, two cycles after the game read is sampled for issue; o_game_label held until next response.
REQ-019 SHALL enter G_IDLE on the rvalid cycle so o_game_ready is high that cycle, permitting back-to-back requests.
REQ-020 SHALL clear o_game_wait at handshake, increment each cycle in G_PEND, saturate at 16'hFFFF, hold in G_WAIT/G_IDLE.
REQ-021 SHALL hold o_disp_label at its last value when o_disp_valid is low.

Reset
REQ-022 SHALL, in the cycle after i_rst high, force o_mem_en, o_disp_valid, o_game_rvalid to 0, o_game_ready to 1, labels/o_mem_addr/o_game_wait to 0, state G_IDLE.
REQ-023 SHALL discard pending and in-flight requests on reset mid-operation; no response emitted for them.

Configuration
REQ-024 SHALL implement macro BG_OOB_CLAMP_EN: when defined, requests with x >= 2*HORIZONTAL or y >= 2*VERTICAL issue no memory read (o_mem_en stays 0) yet return label 0 with unchanged latency and handshake timing.
REQ-025 SHALL, without BG_OOB_CLAMP_EN, issue every request's computed address unchecked; returned label unspecified, timing identical.

Structure
REQ-026 SHALL place HORIZONTAL/VERTICAL defaults, PIXEL_BITS, address width 17 and game-state enum in shared package bg_pkg.
REQ-027 SHALL use one sub-module bg_addr_gen (coordinate to address plus OOB flag), instantiated for the display and game paths.

Verification
REQ-028 SHALL test display stream x=0..639 step 1 at y=10, i_disp_req continuous -> o_disp_valid continuous from cycle 2, addresses 1600..1919 each repeated twice.
REQ-029 SHALL test game request (x=100,y=50) while display idle -> o_mem_addr=8050 next cycle, o_game_rvalid two cycles later, label = memory content.
REQ-030 SHALL test game handshake during 20-cycle display burst -> o_game_wait reaches 20, read issued first idle cycle, display latency unaffected.
REQ-031 SHALL test request (x=700,y=0) with BG_OOB_CLAMP_EN -> no o_mem_en, label 0 at latency 2; without macro -> o_mem_en with address 350.
REQ-032 SHALL test i_rst asserted in G_WAIT -> no o_game_rvalid, o_game_ready=1 cycle after reset, o_game_wait=0.
REQ-033 SHALL test back-to-back game requests with display idle -> one response every 3 cycles, ready high on each rvalid cycle.
